// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with line refill, snoop/flush invalidation and miss counter
module icache_dm #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int SETS       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              flush,
  output logic [15:0]       miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // storage; array contents are deliberately left unreset
  logic [DATA_W-1:0] r_data [SETS*LINE_WORDS];
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [SETS-1:0]   r_valid;
  logic [SETS-1:0]   w_valid_next;

  // line currently being refilled
  logic [TAG_W-1:0]  r_line_tag;
  logic [IDX_W-1:0]  r_line_idx;
  logic [OFF_W-1:0]  r_word_cnt;
  logic              r_poison;

  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid;
  logic [15:0]       r_miss_cnt;

  // fetch address fields
  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;

  // snoop address fields
  logic [IDX_W-1:0]  w_s_idx;
  logic [TAG_W-1:0]  w_s_tag;

  logic              w_hit;
  logic              w_miss;
  logic              w_ack;
  logic              w_last;
  logic              w_snoop_hit;
  logic              w_snoop_line;
  logic              w_kill;
  logic              w_unused_bits;

  assign w_off   = addr[2 +: OFF_W];
  assign w_idx   = addr[2+OFF_W +: IDX_W];
  assign w_tag   = addr[ADDR_W-1 -: TAG_W];
  assign w_s_idx = snoop_addr[2+OFF_W +: IDX_W];
  assign w_s_tag = snoop_addr[ADDR_W-1 -: TAG_W];

  // byte-within-word bits carry no information for a word-wide cache
  assign w_unused_bits = &{1'b0, addr[1:0], snoop_addr[1:0]};

  assign w_hit  = req && (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss = req && (r_state == S_IDLE) && !w_hit;

  // acks outside REFILL have no meaning and are dropped here
  assign w_ack  = (r_state == S_REFILL) && mem_ack;
  assign w_last = w_ack && (r_word_cnt == OFF_W'(LINE_WORDS - 1));

  // a store to a resident line kills it wherever the FSM is
  assign w_snoop_hit  = snoop_we && r_valid[w_s_idx] && (r_tag[w_s_idx] == w_s_tag);

  // a store into the line being fetched makes the incoming copy stale
  assign w_snoop_line = snoop_we && (r_state == S_REFILL) &&
                        (w_s_idx == r_line_idx) && (w_s_tag == r_line_tag);

  assign w_kill = flush || w_snoop_line;

  assign mem_addr = {r_line_tag, r_line_idx, r_word_cnt, 2'b00};
  assign dout     = r_dout;
  assign dvalid   = r_dvalid;
  assign miss_cnt = r_miss_cnt;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_miss;
        if (w_miss) begin
          w_next_state = S_REFILL;
        end
      end
      S_REFILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (w_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // next valid vector: flush dominates, then completion of a clean refill
  always_comb begin
    w_valid_next = r_valid;
    if (w_miss) begin
      w_valid_next[w_idx] = 1'b0;
    end
    if (w_snoop_hit) begin
      w_valid_next[w_s_idx] = 1'b0;
    end
    if (w_last) begin
      w_valid_next[r_line_idx] = !r_poison && !w_kill;
    end
    if (flush) begin
      w_valid_next = '0;
    end
  end

  // valid bits and poison flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_poison <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      if (w_miss) begin
        r_poison <= 1'b0;
      end else if ((r_state == S_REFILL) && w_kill) begin
        r_poison <= 1'b1;
      end
    end
  end

  // refill bookkeeping: line base latched on miss, word counter advanced per ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_tag <= '0;
      r_line_idx <= '0;
      r_word_cnt <= '0;
    end else if (w_miss) begin
      r_line_tag <= w_tag;
      r_line_idx <= w_idx;
      r_word_cnt <= '0;
    end else if (w_ack) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // saturating count of refills started
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss_cnt <= '0;
    end else if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
      r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  // data and tag array writes during refill
  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_data[{r_line_idx, r_word_cnt}] <= mem_data;
    end
    if (w_last) begin
      r_tag[r_line_idx] <= r_line_tag;
    end
  end

  // registered hit read; dout holds its value when nothing hits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= w_hit;
      if (w_hit) begin
        r_dout <= r_data[{w_idx, w_off}];
      end
    end
  end

endmodule
